// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch controller for beq/bne.
// Detects operand hazards against EX/MEM, stalls the front end 0..2 cycles,
// then drives PC redirect and IF/ID flush from the comparator result.
// Optional macro BRANCH_STATS_EN adds branch/taken/stall counters.
module branch_resolve_unit #(
    parameter logic [5:0] BEQ_OP = 6'h04,
    parameter logic [5:0] BNE_OP = 6'h05
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [15:0] id_imm,
    input  logic [31:0] id_pc_plus4,
    input  logic        cmp_equal,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        if_flush,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        id_bubble
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stalls
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_RESOLVE} state_t;

    state_t     r_state, w_next;
    logic       r_cnt, w_cnt_next;
    logic       w_is_br, w_is_beq, w_is_bne, w_taken;
    logic       w_ex_match, w_mem_match;
    logic [1:0] w_h;
    logic       w_stall, w_resolve;

    assign w_is_beq = (id_opcode == BEQ_OP);
    assign w_is_bne = (id_opcode == BNE_OP);
    assign w_is_br  = id_valid & (w_is_beq | w_is_bne);
    assign w_taken  = (w_is_beq & cmp_equal) | (w_is_bne & ~cmp_equal);

    // Register 0 never carries a real dependency.
    assign w_ex_match  = (ex_rd  != 5'd0) & ((ex_rd  == id_rs) | (ex_rd  == id_rt));
    assign w_mem_match = (mem_rd != 5'd0) & ((mem_rd == id_rs) | (mem_rd == id_rt));

    // Load in EX needs two bubbles; ALU result in EX or load in MEM needs one.
    assign w_h = (ex_mem_read & w_ex_match) ? 2'd2 :
                 ((ex_reg_write & w_ex_match) | (mem_mem_read & w_mem_match)) ? 2'd1 : 2'd0;

    // Offset is in words, so scale by 4 after sign extension; wraps mod 2^32.
    assign branch_target = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};

    // State and extra-stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and stall/resolve decision; a dropped id_valid abandons the branch.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_stall    = 1'b0;
        w_resolve  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_br) begin
                    if (w_h == 2'd0) begin
                        w_resolve = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        if (w_h == 2'd2) begin
                            w_next     = S_STALL;
                            w_cnt_next = 1'b0;   // no further stall beyond STALL itself
                        end else begin
                            w_next = S_RESOLVE;
                        end
                    end
                end
            end
            S_STALL: begin
                if (!id_valid) begin
                    w_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == 1'b0) w_next = S_RESOLVE;
                    else               w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RESOLVE: begin
                w_next = S_IDLE;
                if (id_valid) w_resolve = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stall and redirect are mutually exclusive by construction of the FSM.
    assign pc_write   = ~w_stall;
    assign ifid_write = ~w_stall;
    assign id_bubble  = w_stall;
    assign pc_src     = w_resolve & w_taken;
    assign if_flush   = w_resolve & w_taken;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches, r_stat_taken, r_stat_stalls;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= 32'd0;
            r_stat_taken    <= 32'd0;
            r_stat_stalls   <= 32'd0;
        end else begin
            if (w_resolve)           r_stat_branches <= r_stat_branches + 32'd1;
            if (w_resolve & w_taken) r_stat_taken    <= r_stat_taken + 32'd1;
            if (w_stall)             r_stat_stalls   <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_taken    = r_stat_taken;
    assign stat_stalls   = r_stat_stalls;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed cases plus random traffic,
// expected outputs queued per cycle by a reference model and checked by a monitor.
module tb_branch_resolve_unit;

    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;

    logic        clk, rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt;
    logic [15:0] id_imm;
    logic [31:0] id_pc_plus4;
    logic        cmp_equal, ex_reg_write, ex_mem_read, mem_mem_read;
    logic [4:0]  ex_rd, mem_rd;
    logic        pc_src, if_flush, pc_write, ifid_write, id_bubble;
    logic [31:0] branch_target;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_taken, stat_stalls;
`endif

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
        .cmp_equal(cmp_equal), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .pc_src(pc_src), .branch_target(branch_target), .if_flush(if_flush),
        .pc_write(pc_write), .ifid_write(ifid_write), .id_bubble(id_bubble)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
`endif
    );

    typedef struct {
        logic        valid;
        logic [5:0]  opc;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        cmp, exw, exr;
        logic [4:0]  exrd;
        logic        memr;
        logic [4:0]  memrd;
    } stim_t;

    typedef struct {
        logic        pc_src, if_flush, pc_write, ifid_write, id_bubble;
        logic [31:0] target;
        int unsigned br, tk, st;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state: is a branch being held, and how many more stall cycles.
    bit          m_busy = 0;
    int          m_rem = 0;
    int unsigned m_br = 0, m_tk = 0, m_st = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic [5:0] o, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [15:0] imm,
                                 input logic [31:0] pc, input logic cmp, input logic exw,
                                 input logic exr, input logic [4:0] exrd,
                                 input logic memr, input logic [4:0] memrd);
        stim_t s;
        s.valid = v; s.opc = o; s.rs = rs; s.rt = rt; s.imm = imm; s.pc = pc;
        s.cmp = cmp; s.exw = exw; s.exr = exr; s.exrd = exrd; s.memr = memr; s.memrd = memrd;
        return s;
    endfunction

    function automatic bit dep(input logic [4:0] d, input stim_t s);
        return (d != 0) && (d == s.rs || d == s.rt);
    endfunction

    function automatic int hazard(input stim_t s);
        if (s.exr && dep(s.exrd, s)) return 2;
        if ((s.exw && dep(s.exrd, s)) || (s.memr && dep(s.memrd, s))) return 1;
        return 0;
    endfunction

    // Issue one cycle of stimulus, queue the expected response, advance the model at the edge.
    task automatic cyc(input stim_t s, input logic rst);
        exp_t e;
        bit   br, tk, stall, resolve, nbusy;
        int   nrem, off;
        id_valid = s.valid; id_opcode = s.opc; id_rs = s.rs; id_rt = s.rt;
        id_imm = s.imm; id_pc_plus4 = s.pc; cmp_equal = s.cmp;
        ex_reg_write = s.exw; ex_mem_read = s.exr; ex_rd = s.exrd;
        mem_mem_read = s.memr; mem_rd = s.memrd;
        rst_n = rst;
        if (!rst) begin
            m_busy = 0; m_rem = 0; m_br = 0; m_tk = 0; m_st = 0;
        end
        off = int'($signed(s.imm));
        e.target = s.pc + 32'(off * 4);
        br = s.valid && (s.opc == BEQ || s.opc == BNE);
        tk = (s.opc == BEQ && s.cmp) || (s.opc == BNE && !s.cmp);
        stall = 0; resolve = 0; nbusy = m_busy; nrem = m_rem;
        if (m_busy) begin
            if (!s.valid) nbusy = 0;
            else if (m_rem > 0) begin stall = 1; nrem = m_rem - 1; end
            else begin resolve = 1; nbusy = 0; end
        end else if (br) begin
            if (hazard(s) == 0) resolve = 1;
            else begin stall = 1; nbusy = 1; nrem = hazard(s) - 1; end
        end
        e.pc_write   = !stall;
        e.ifid_write = !stall;
        e.id_bubble  = stall;
        e.pc_src     = resolve && tk;
        e.if_flush   = resolve && tk;
        e.br = m_br; e.tk = m_tk; e.st = m_st;
        q.push_back(e);
        @(posedge clk); #1;
        if (rst) begin
            m_busy = nbusy; m_rem = nrem;
            if (resolve) m_br++;
            if (resolve && tk) m_tk++;
            if (stall) m_st++;
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_src", 32'(pc_src), 32'(e.pc_src));
            chk("if_flush", 32'(if_flush), 32'(e.if_flush));
            chk("pc_write", 32'(pc_write), 32'(e.pc_write));
            chk("ifid_write", 32'(ifid_write), 32'(e.ifid_write));
            chk("id_bubble", 32'(id_bubble), 32'(e.id_bubble));
            chk("branch_target", branch_target, e.target);
            chk("stall_flush_excl", 32'(!pc_write && if_flush), 32'(0));
`ifdef BRANCH_STATS_EN
            chk("stat_branches", stat_branches, e.br);
            chk("stat_taken", stat_taken, e.tk);
            chk("stat_stalls", stat_stalls, e.st);
`endif
        end
    end

    initial begin
        stim_t idle, s;
        idle = mk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_imm = 0; id_pc_plus4 = 0;
        cmp_equal = 0; ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0;
        @(posedge clk); #1;
        cyc(idle, 0);
        cyc(idle, 0);
        cyc(idle, 1);

        // beq, no hazard, taken: redirect to 0x110 in the same cycle
        cyc(mk(1, BEQ, 1, 2, 16'h0004, 32'h100, 1, 0, 0, 0, 0, 0), 1);
        // bne, ALU hazard in EX on rs: one stall, then taken
        s = mk(1, BNE, 5, 3, 16'h0010, 32'h200, 0, 1, 0, 5, 0, 0);
        cyc(s, 1);
        cyc(s, 1);
        // beq, load-use in EX on rt: two stalls, hazard inputs toggled meanwhile
        s = mk(1, BEQ, 4, 7, 16'hFFF0, 32'h1000, 1, 0, 1, 7, 0, 0);
        cyc(s, 1);
        s.exr = 0; s.memr = 1; s.memrd = 7; s.cmp = 0;
        cyc(s, 1);
        s.exw = 1; s.exr = 1; s.cmp = 1;
        cyc(s, 1);
        // rd=0 never counts as a dependency; negative offset wraps to 0
        cyc(mk(1, BEQ, 0, 0, 16'hFFFF, 32'h4, 1, 1, 1, 0, 1, 0), 1);
        // valid drop mid-stall abandons the branch
        s = mk(1, BNE, 9, 10, 16'h0001, 32'h40, 0, 0, 1, 9, 0, 0);
        cyc(s, 1);
        cyc(idle, 1);
        cyc(idle, 1);
        // reset asserted mid-stall
        cyc(s, 1);
        cyc(idle, 0);
        cyc(idle, 1);

        // stats: h=2 taken, h=0 not taken, h=1 taken
        s = mk(1, BEQ, 1, 7, 16'h0002, 32'h80, 1, 0, 1, 7, 0, 0);
        cyc(s, 1); cyc(s, 1); cyc(s, 1);
        cyc(mk(1, BNE, 2, 3, 16'h0003, 32'h90, 1, 0, 0, 0, 0, 0), 1);
        s = mk(1, BEQ, 6, 8, 16'h0004, 32'hA0, 1, 1, 0, 6, 0, 0);
        cyc(s, 1); cyc(s, 1);
        cyc(idle, 1);
`ifdef BRANCH_STATS_EN
        chk("stats_branches_3", stat_branches, 32'd3);
        chk("stats_taken_2", stat_taken, 32'd2);
        chk("stats_stalls_3", stat_stalls, 32'd3);
`endif

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            s.valid = ($urandom_range(0, 9) < 8);
            s.opc   = (r < 4) ? BEQ : (r < 8) ? BNE : 6'($urandom_range(0, 63));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.imm   = 16'($urandom);
            s.pc    = $urandom;
            s.cmp   = 1'($urandom);
            s.exw   = 1'($urandom);
            s.exr   = 1'($urandom);
            s.exrd  = 5'($urandom_range(0, 3));
            s.memr  = 1'($urandom);
            s.memrd = 5'($urandom_range(0, 3));
            cyc(s, ($urandom_range(0, 99) != 0));
        end
        cyc(idle, 1);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
